// File: rtl/lane4x2b_serializer.sv
// lane4x2b_serializer
//   Takes one multi-lane word per in_val/in_rdy handshake. It emits the lanes one
//   per cycle on a single stream, lane 0 first, under out_val/out_rdy flow control.
//   A same-cycle handoff on the last lane lets consecutive words stream with no
//   bubble.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset; clears all state while low
//   in_val    upstream word valid
//   in_rdy    word can be accepted this cycle (combinational, depends on out_rdy)
//   in0..in3  word lanes, in0 sent first, in3 sent last
//   out_val   out carries a valid lane (registered state only, not out_rdy)
//   out_rdy   downstream takes the lane this cycle
//   out       current lane value (0 while idle)
//   out_last  current lane is the final lane of its word
//
// The port list carries exactly four lanes, so NLANES is expected to stay 4.
module lane4x2b_serializer #(
  parameter int NLANES = 4,
  parameter int WIDTH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out,
  output logic             out_last
);

  localparam int IDX_W = $clog2(NLANES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx;
  logic [NLANES*WIDTH-1:0]   buffer;
  logic                      last_lane;
  logic                      accept;
  logic                      xfer;

  assign last_lane = (idx == IDX_W'(NLANES - 1));
  assign accept    = in_val & in_rdy;
  assign xfer      = out_val & out_rdy;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      // An accept on the last-lane transfer keeps us in SEND with the new word.
      SEND: if (xfer && last_lane && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane index and word buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      buffer <= '0;
    end else if (accept) begin
      buffer <= {in3, in2, in1, in0};
      idx    <= '0;
    end else if (xfer) begin
      idx    <= last_lane ? '0 : idx + IDX_W'(1);
    end
  end

  // Outputs. in_rdy is held low while reset is asserted so no word is offered
  // a handshake before the block is running.
  always_comb begin
    in_rdy   = reset & ((state == IDLE) | ((state == SEND) & last_lane & out_rdy));
    out_val  = (state == SEND);
    out      = out_val ? buffer[int'(idx)*WIDTH +: WIDTH] : '0;
    out_last = out_val & last_lane;
  end

endmodule

// File: tb/tb_lane4x2b_serializer.sv
module tb_lane4x2b_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [1:0] in0, in1, in2, in3;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] out;
  logic       out_last;

  lane4x2b_serializer #(.NLANES(4), .WIDTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out      (out),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lane;
    logic       last;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_acc;

  // Advance one cycle. Just before the edge, record the handshakes:
  // an accept pushes the four expected lanes, a transfer records what the DUT emitted.
  task automatic tick();
    ent_t e;
    #1;
    last_acc = in_val && in_rdy;
    if (out_val && out_rdy) begin
      e.lane = out;
      e.last = out_last;
      obs_q.push_back(e);
    end
    if (last_acc) begin
      e.lane = in0; e.last = 1'b0; exp_q.push_back(e);
      e.lane = in1; e.last = 1'b0; exp_q.push_back(e);
      e.lane = in2; e.last = 1'b0; exp_q.push_back(e);
      e.lane = in3; e.last = 1'b1; exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input logic [1:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    set_word(2'd0, 2'd0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (out_val !== 1'b0) $display("FAIL reset_out_val got=%b want=0", out_val); else n_pass++;
    n_checks++; if (out !== 2'd0) $display("FAIL reset_out got=%0d want=0", out); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b want=0", out_last); else n_pass++;
    n_checks++; if (in_rdy !== 1'b0) $display("FAIL reset_in_rdy got=%b want=0", in_rdy); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 1'b1) $display("FAIL post_reset_in_rdy got=%b want=1", in_rdy); else n_pass++;
    n_checks++; if (out_val !== 1'b0) $display("FAIL post_reset_out_val got=%b want=0", out_val); else n_pass++;
    tick();
  endtask

  task automatic test_basic();
    ent_t o, e;
    out_rdy = 1'b1; in_val = 1'b1;
    set_word(2'd0, 2'd1, 2'd2, 2'd3);
    tick();
    in_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (out_val !== 1'b1) $display("FAIL basic_val lane%0d got=%b want=1", k, out_val); else n_pass++;
      n_checks++; if (out !== 2'(k)) $display("FAIL basic_out lane%0d got=%0d want=%0d", k, out, k); else n_pass++;
      n_checks++; if (out_last !== (k == 3)) $display("FAIL basic_last lane%0d got=%b want=%b", k, out_last, (k == 3)); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (out_val !== 1'b0) $display("FAIL basic_idle_val got=%b want=0", out_val); else n_pass++;
    n_checks++; if (in_rdy !== 1'b1) $display("FAIL basic_idle_rdy got=%b want=1", in_rdy); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL basic_sb got=%0d/%b want=%0d/%b", o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    ent_t o, e;
    out_rdy = 1'b0; in_val = 1'b1;
    set_word(2'd3, 2'd0, 2'd1, 2'd2);
    tick();
    in_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (out_val !== 1'b1 || out !== 2'd3)
        $display("FAIL bp_hold cyc%0d got=%b/%0d want=1/3", k, out_val, out); else n_pass++;
      tick();
    end
    out_rdy = 1'b1;
    repeat (4) tick();
    #1;
    n_checks++; if (out_val !== 1'b0) $display("FAIL bp_idle_val got=%b want=0", out_val); else n_pass++;
    n_checks++; if (obs_q.size() != 4 || exp_q.size() != 4)
      $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL bp_sb got=%0d/%b want=%0d/%b", o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ent_t o, e;
    out_rdy = 1'b1; in_val = 1'b1;
    set_word(2'd2, 2'd3, 2'd0, 2'd1);
    tick();
    set_word(2'd1, 2'd2, 2'd3, 2'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (out_val !== 1'b1) $display("FAIL b2b_val cyc%0d got=%b want=1", k, out_val); else n_pass++;
      if (k == 3) begin
        n_checks++; if (in_rdy !== 1'b1) $display("FAIL b2b_handoff_rdy got=%b want=1", in_rdy); else n_pass++;
      end
      tick();
      if (k == 3) in_val = 1'b0;
    end
    n_checks++; if (obs_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL b2b_sb got=%0d/%b want=%0d/%b", o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy_ignore();
    ent_t o, e;
    out_rdy = 1'b1; in_val = 1'b1;
    set_word(2'd0, 2'd0, 2'd1, 2'd1);
    tick();
    set_word(2'd3, 2'd3, 2'd3, 2'd3);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (in_rdy !== (k == 3)) $display("FAIL busy_rdy lane%0d got=%b want=%b", k, in_rdy, (k == 3)); else n_pass++;
      tick();
    end
    in_val = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL busy_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL busy_sb got=%0d/%b want=%0d/%b", o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    ent_t o, e;
    out_rdy = 1'b1; in_val = 1'b1;
    set_word(2'd0, 2'd1, 2'd1, 2'd0);
    tick();
    in_val = 1'b0;
    tick();
    #1;
    n_checks++; if (out !== 2'd1) $display("FAIL rst_mid_lane1 got=%0d want=1", out); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (out_val !== 1'b0 || out !== 2'd0 || out_last !== 1'b0)
      $display("FAIL rst_mid_drop got=%b/%0d/%b want=0/0/0", out_val, out, out_last); else n_pass++;
    n_checks++; if (obs_q.size() != 1) $display("FAIL rst_mid_count got=%0d want=1", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL rst_mid_sb got=%0d/%b want=%0d/%b", o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (out_val !== 1'b0) $display("FAIL rst_mid_after cyc%0d got=%b want=0", k, out_val); else n_pass++;
      tick();
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL rst_mid_leak got=%0d want=0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    ent_t o, e;
    int sent = 0;
    int cyc  = 0;
    int xfers = 0;
    while ((sent < 20 || obs_q.size() < exp_q.size()) && cyc < 3000) begin
      out_rdy = 1'($urandom_range(0, 1));
      in_val  = (sent < 20);
      set_word(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    in_val = 1'b0;
    n_checks++; if (cyc >= 3000) $display("FAIL rand_timeout got=%0d cycles want<3000", cyc); else n_pass++;
    n_checks++; if (sent != 20 || exp_q.size() != 80 || obs_q.size() != 80)
      $display("FAIL rand_count got=%0d words/%0d lanes want=20/80", sent, obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      xfers++;
      n_checks++; if (o !== e || o.last !== (xfers % 4 == 0))
        $display("FAIL rand_sb xfer%0d got=%0d/%b want=%0d/%b", xfers, o.lane, o.last, e.lane, e.last); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lane4x2b_serializer.md
Name: lane4x2b_serializer

Overview:
Downstream consumer of the 4-lane x 2-bit passthrough stage. It accepts one 4-lane word (in0..in3) per val/rdy handshake and emits the lanes one per cycle on a single 2-bit output stream, in0 first. A valid/ready handshake on the output side provides backpressure. out_last marks the final lane of each word.

Parameters:
NLANES, 4, number of input lanes per word; must be a power of 2 and >= 2
WIDTH, 2, bit width of each lane and of the output stream

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
in_val  input  1  upstream word valid
in_rdy  output  1  serializer can accept a word this cycle
in0  input  WIDTH  lane 0, sent first
in1  input  WIDTH  lane 1
in2  input  WIDTH  lane 2
in3  input  WIDTH  lane 3, sent last
out_val  output  1  out holds a valid lane
out_rdy  input  1  downstream accepts the lane this cycle
out  output  WIDTH  current lane value
out_last  output  1  current lane is lane NLANES-1

Behaviour:
- Reset: asynchronous, active-low. While reset=0: state=IDLE, idx=0, buffer=0, out_val=0, out=0, out_last=0, in_rdy=0. The first rising edge after reset returns to 1 sees IDLE.
- State: two-state FSM, IDLE and SEND. A buffer holds NLANES x WIDTH bits. A lane index idx is log2(NLANES) bits.
- Input accept: fires when in_val & in_rdy at a rising edge. On accept, buffer <= {in3,in2,in1,in0}, idx <= 0, state <= SEND.
- Output transfer: fires when out_val & out_rdy at a rising edge. On transfer, idx <= idx+1.
- in_rdy is combinational: 1 in IDLE, or in SEND when idx==NLANES-1 and out_rdy=1. This gives a same-cycle handoff, so words can run back-to-back at one lane per cycle with no bubble.
- out_val = (state==SEND). out = buffer lane selected by idx. out_last = out_val & (idx==NLANES-1). When state is IDLE, out is 0.
- Transitions:
  - IDLE -> SEND on input accept.
  - SEND, last-lane transfer with no simultaneous accept: -> IDLE, idx <= 0.
  - SEND, last-lane transfer with simultaneous accept: stay in SEND, load the new word, idx <= 0.
  - SEND with out_rdy=0: hold. idx, buffer and out stay stable, and out_val stays 1.
- Latency: a word accepted at edge N presents lane 0 during cycle N+1. With out_rdy held at 1, lane k presents during cycle N+1+k.
- in_val while busy (in_rdy=0) is ignored. No capture occurs, and the input lanes may change freely.
- idx wraps from NLANES-1 to 0 only through the transitions above and never overflows into an extra state.
- Reset mid-word: the buffered word is discarded and no remaining lanes are emitted. After reset, out_val=0 until the next accept.
- out_val must not depend combinationally on out_rdy. in_rdy may depend on out_rdy.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Basic: accept (in0..in3)=(0,1,2,3) with out_rdy=1 -> out=0,1,2,3 on the next 4 cycles, out_last=1 only with 3, then out_val=0 and in_rdy=1.
- Backpressure: word (3,0,1,2), out_rdy=0 for 3 cycles after lane 0 appears -> out holds 3 with out_val=1, then 0,1,2 follow once out_rdy=1. No lane is dropped or duplicated.
- Back-to-back: in_val=1 continuously with words (2,3,0,1) then (1,2,3,0), out_rdy=1 -> 8 consecutive valid lanes 2,3,0,1,1,2,3,0. in_rdy=1 on the last-lane cycle. No bubble.
- Busy ignore: while sending (0,0,1,1), drive in_val=1 with (3,3,3,3) during lanes 0-2 -> in_rdy=0 on those cycles, and 0,0,1,1 is emitted unchanged. (3,3,3,3) is accepted on the last-lane cycle.
- Reset mid-word: assert reset=0 asynchronously during lane 1 of (0,1,1,0) -> out_val, out and out_last drop to 0 immediately. After release, out_val stays 0 until a new accept.
- Random: 20 random words with random out_rdy -> the output lane sequence equals the concatenated input lanes in0..in3 per word, and out_last falls on every 4th transfer.
